// File: rtl/match_select_decoder_pkg.sv
// compress_pkg: shared width helpers and result type for the match-select datapath
package compress_pkg;
  function automatic int lw_f(input int bytes);
    return $clog2(bytes + 1);
  endfunction
  function automatic int iw_f(input int depth);
    return $clog2(depth);
  endfunction
  localparam int BYTES_DEF = 4;
  localparam int DEPTH_DEF = 16;
  localparam int LW_DEF = lw_f(BYTES_DEF);
  localparam int IW_DEF = iw_f(DEPTH_DEF);
  typedef struct packed {
    logic              hit;
    logic [LW_DEF-1:0] match_type;
    logic [LW_DEF-1:0] match_len;
    logic [IW_DEF-1:0] index;
  } match_result_t;
endpackage

// File: rtl/match_select_decoder_if.sv
// match_select_decoder_if: upstream compare-vector and downstream result handshakes
interface match_select_decoder_if
  import compress_pkg::*;
#(
  parameter int BYTES = 4,
  parameter int DEPTH = 16
);
  localparam int LW = lw_f(BYTES);
  localparam int IW = iw_f(DEPTH);
  logic                   i_valid;
  logic                   o_ready;
  logic [DEPTH*BYTES-1:0] i_compare_vec;
  logic [DEPTH-1:0]       i_entry_valid;
  logic                   i_partial_en;
  logic                   o_valid;
  logic                   i_ready;
  logic                   o_hit;
  logic [LW-1:0]          o_match_type;
  logic [LW-1:0]          o_match_len;
  logic [IW-1:0]          o_index;
  modport slave (
    input  i_valid, i_compare_vec, i_entry_valid, i_partial_en, i_ready,
    output o_ready, o_valid, o_hit, o_match_type, o_match_len, o_index
  );
  modport master (
    output i_valid, i_compare_vec, i_entry_valid, i_partial_en, i_ready,
    input  o_ready, o_valid, o_hit, o_match_type, o_match_len, o_index
  );
endinterface

// File: rtl/match_select_decoder_word_len_decoder.sv
// word_len_decoder: qualified contiguous-prefix match length of one compare vector
module word_len_decoder
  import compress_pkg::*;
#(
  parameter int BYTES = 4,
  parameter int MIN_MATCH = 2,
  localparam int LW = lw_f(BYTES)
) (
  input  logic [BYTES-1:0] compare_vec_i,
  input  logic             entry_valid_i,
  input  logic             partial_en_i,
  output logic [LW-1:0]    len_o
);
  localparam logic [BYTES-1:0] all_ones = '1;
  logic [LW-1:0] run_len;
  // length k when the vector is exactly k ones starting at byte 0 followed by zeros
  always_comb begin
    run_len = '0;
    for (int k = 1; k <= BYTES; k++) run_len = (compare_vec_i == ~(all_ones >> k)) ? LW'(k) : run_len;
  end
  assign len_o = (entry_valid_i && run_len >= LW'(MIN_MATCH) && (partial_en_i || run_len == LW'(BYTES))) ? run_len : '0;
endmodule

// File: rtl/match_select_decoder.sv
// match_select_decoder: two-stage elastic pipeline picking the longest dictionary match
module match_select_decoder
  import compress_pkg::*;
#(
  parameter int BYTES = 4,
  parameter int DEPTH = 16,
  parameter int MIN_MATCH = 2
) (
  input logic                   i_clk,
  input logic                   i_rst_n,
  match_select_decoder_if.slave bus
);
  localparam int LW = lw_f(BYTES);
  localparam int IW = iw_f(DEPTH);
  logic [DEPTH-1:0][LW-1:0] len_d, len_q;
  logic                     s1_valid_q, s2_valid_q, s1_ready, s2_ready, accept;
  logic [LW-1:0]            best_len, type_d, type_q, match_len_q;
  logic [IW-1:0]            best_idx, index_q;
  logic                     hit_q;
  genvar e;
  for (e = 0; e < DEPTH; e++) begin : g_dec
    word_len_decoder #(.BYTES(BYTES), .MIN_MATCH(MIN_MATCH)) u_dec (
      .compare_vec_i (bus.i_compare_vec[e*BYTES +: BYTES]),
      .entry_valid_i (bus.i_entry_valid[e]),
      .partial_en_i  (bus.i_partial_en),
      .len_o         (len_d[e])
    );
  end
  assign s2_ready = !s2_valid_q || bus.i_ready;
  assign s1_ready = !s1_valid_q || s2_ready;
  assign accept   = bus.i_valid && s1_ready;
  // argmax with strict greater-than so the lowest index keeps ties
  always_comb begin
    best_len = '0;
    best_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (len_q[i] > best_len) begin
        best_len = len_q[i];
        best_idx = IW'(i);
      end
    end
  end
  assign type_d = (best_len == '0) ? '0 : best_len - LW'(MIN_MATCH - 1);
  // stage 1: capture decoded lengths on accepted transfers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      len_q      <= '0;
    end else begin
      if (s1_ready) s1_valid_q <= bus.i_valid;
      if (accept) len_q <= len_d;
    end
  end
  // stage 2: register the selected result, holding while downstream stalls
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_valid_q  <= 1'b0;
      hit_q       <= 1'b0;
      type_q      <= '0;
      match_len_q <= '0;
      index_q     <= '0;
    end else if (s2_ready) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        hit_q       <= best_len != '0;
        type_q      <= type_d;
        match_len_q <= best_len;
        index_q     <= best_idx;
      end
    end
  end
  assign bus.o_ready      = s1_ready;
  assign bus.o_valid      = s2_valid_q;
  assign bus.o_hit        = hit_q;
  assign bus.o_match_type = type_q;
  assign bus.o_match_len  = match_len_q;
  assign bus.o_index      = index_q;
endmodule

// File: tb/tb_match_select_decoder.sv
// tb_match_select_decoder: directed and randomized checks against a behavioural model
module tb_match_select_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;

  match_select_decoder_if #(.BYTES(4), .DEPTH(4)) b ();
  match_select_decoder_if #(.BYTES(4), .DEPTH(4)) b1 ();

  match_select_decoder #(.BYTES(4), .DEPTH(4), .MIN_MATCH(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(b.slave)
  );
  match_select_decoder #(.BYTES(4), .DEPTH(4), .MIN_MATCH(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(b1.slave)
  );

  assign b1.i_valid       = b.i_valid;
  assign b1.i_compare_vec = b.i_compare_vec;
  assign b1.i_entry_valid = b.i_entry_valid;
  assign b1.i_partial_en  = b.i_partial_en;
  assign b1.i_ready       = b.i_ready;

  logic [9:0] out, out1;
  assign out  = {b.o_valid, b.o_hit, b.o_match_type, b.o_match_len, b.o_index};
  assign out1 = {b1.o_valid, b1.o_hit, b1.o_match_type, b1.o_match_len, b1.o_index};

  // expected {hit, type, len, index} from the matching rules, using integer arithmetic
  function automatic logic [8:0] model(input logic [15:0] vec, input logic [3:0] ev, input logic pe, input int mm);
    int best, bi, n, v;
    best = 0;
    bi = 0;
    for (int e = 0; e < 4; e++) begin
      v = int'((vec >> (4 * e)) & 16'hF);
      n = 0;
      while (n < 4 && ((v >> (3 - n)) & 1) == 1) n++;
      if (v != (((1 << n) - 1) << (4 - n))) n = 0;
      if (((ev >> e) & 4'd1) == 4'd0 || n < mm || (!pe && n != 4)) n = 0;
      if (n > best) begin
        best = n;
        bi = e;
      end
    end
    return {best != 0, 3'(best == 0 ? 0 : best - mm + 1), 3'(best), 2'(bi)};
  endfunction

  task automatic send(input logic [15:0] vec, input logic [3:0] ev, input logic pe);
    b.i_valid = 1'b1;
    b.i_compare_vec = vec;
    b.i_entry_valid = ev;
    b.i_partial_en = pe;
    b.i_ready = 1'b1;
    @(posedge clk); #1;
    b.i_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    #12;
    total++;
    if ({out, b.o_ready} !== {10'd0, 1'b1}) begin
      bad++;
      $display("FAIL reset_hold: got out=%b ready=%b want out=0 ready=1", out, b.o_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({out, b.o_ready} !== {10'd0, 1'b1}) begin
      bad++;
      $display("FAIL reset_release: got out=%b ready=%b want out=0 ready=1", out, b.o_ready);
    end
  endtask

  task automatic test_basic;
    b.i_valid = 1'b1;
    b.i_compare_vec = 16'h5EC0;
    b.i_entry_valid = 4'hF;
    b.i_partial_en = 1'b1;
    b.i_ready = 1'b1;
    @(posedge clk); #1;
    b.i_valid = 1'b0;
    total++;
    if (b.o_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_latency: o_valid=%b one cycle after accept, want 0", b.o_valid);
    end
    @(posedge clk); #1;
    total++;
    if (out !== {1'b1, 1'b1, 3'd2, 3'd3, 2'd2}) begin
      bad++;
      $display("FAIL basic: got %b want %b", out, {1'b1, 1'b1, 3'd2, 3'd3, 2'd2});
    end
  endtask

  task automatic test_tie_mask;
    send(16'hFCFC, 4'hF, 1'b1);
    total++;
    if (out !== {1'b1, 1'b1, 3'd3, 3'd4, 2'd1}) begin
      bad++;
      $display("FAIL tie: got %b want %b", out, {1'b1, 1'b1, 3'd3, 3'd4, 2'd1});
    end
    send(16'hFCFC, 4'b1101, 1'b1);
    total++;
    if (out !== {1'b1, 1'b1, 3'd3, 3'd4, 2'd3}) begin
      bad++;
      $display("FAIL mask: got %b want %b", out, {1'b1, 1'b1, 3'd3, 3'd4, 2'd3});
    end
  endtask

  task automatic test_no_match;
    send(16'hB780, 4'hF, 1'b1);
    total++;
    if (out !== {1'b1, 9'd0}) begin
      bad++;
      $display("FAIL no_match: got %b want %b", out, {1'b1, 9'd0});
    end
    total++;
    if (out1 !== {1'b1, 1'b1, 3'd1, 3'd1, 2'd1}) begin
      bad++;
      $display("FAIL min1_e1: got %b want %b", out1, {1'b1, 1'b1, 3'd1, 3'd1, 2'd1});
    end
    send(16'h0800, 4'hF, 1'b1);
    total++;
    if (out !== {1'b1, 9'd0}) begin
      bad++;
      $display("FAIL min2_single: got %b want %b", out, {1'b1, 9'd0});
    end
    total++;
    if (out1 !== {1'b1, 1'b1, 3'd1, 3'd1, 2'd2}) begin
      bad++;
      $display("FAIL min1_e2: got %b want %b", out1, {1'b1, 1'b1, 3'd1, 3'd1, 2'd2});
    end
  endtask

  task automatic test_full_only;
    send(16'hEFC0, 4'hF, 1'b0);
    total++;
    if (out !== {1'b1, 1'b1, 3'd3, 3'd4, 2'd2}) begin
      bad++;
      $display("FAIL full_only_hit: got %b want %b", out, {1'b1, 1'b1, 3'd3, 3'd4, 2'd2});
    end
    send(16'hEC00, 4'hF, 1'b0);
    total++;
    if (out !== {1'b1, 9'd0}) begin
      bad++;
      $display("FAIL full_only_miss: got %b want %b", out, {1'b1, 9'd0});
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] pat [5] = '{16'h000F, 16'h00F0, 16'h0F00, 16'hF000, 16'h00C0};
    logic [8:0] q[$];
    logic [9:0] prev = '0;
    logic stall = 1'b0;
    int sent = 0;
    int got = 0;
    b.i_valid = 1'b0;
    b.i_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < 20; c++) begin
      b.i_ready = !(c >= 2 && c <= 5);
      b.i_valid = sent < 5;
      b.i_compare_vec = pat[sent < 5 ? sent : 0];
      b.i_entry_valid = 4'hF;
      b.i_partial_en = 1'b1;
      @(negedge clk);
      total++;
      if (b.o_ready !== (q.size() < 2 || b.i_ready)) begin
        bad++;
        $display("FAIL bp_ready: cycle %0d got %b want %b", c, b.o_ready, q.size() < 2 || b.i_ready);
      end
      if (stall) begin
        total++;
        if (out !== prev) begin
          bad++;
          $display("FAIL bp_hold: cycle %0d got %b want %b", c, out, prev);
        end
      end
      stall = b.o_valid && !b.i_ready;
      prev = out;
      if (b.o_valid && b.i_ready) begin
        total++;
        if (q.size() == 0 || out !== {1'b1, q[0]} || c != 6 + got) begin
          bad++;
          $display("FAIL bp_out: cycle %0d result %0d got %b want %b at cycle %0d", c, got, out,
                   q.size() == 0 ? 10'd0 : {1'b1, q[0]}, 6 + got);
        end
        if (q.size() > 0) void'(q.pop_front());
        got++;
      end
      if (b.i_valid && b.o_ready) begin
        q.push_back(model(b.i_compare_vec, b.i_entry_valid, b.i_partial_en, 2));
        sent++;
      end
      @(posedge clk); #1;
    end
    b.i_valid = 1'b0;
    total++;
    if (got != 5 || sent != 5) begin
      bad++;
      $display("FAIL bp_count: got sent=%0d received=%0d want 5 and 5", sent, got);
    end
  endtask

  task automatic test_random;
    logic [8:0] q[$];
    logic [9:0] prev = '0;
    logic stall = 1'b0;
    logic [15:0] vec;
    logic [3:0] sl;
    int k;
    b.i_valid = 1'b0;
    b.i_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < 600; c++) begin
      vec = '0;
      for (int s = 0; s < 4; s++) begin
        k = $urandom_range(0, 4);
        sl = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'(((1 << k) - 1) << (4 - k));
        vec = {vec[11:0], sl};
      end
      b.i_compare_vec = vec;
      b.i_entry_valid = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      b.i_partial_en = $urandom_range(0, 3) != 0;
      b.i_valid = c < 570 && $urandom_range(0, 3) != 0;
      b.i_ready = c >= 570 || $urandom_range(0, 2) != 0;
      @(negedge clk);
      total++;
      if (b.o_ready !== (q.size() < 2 || b.i_ready)) begin
        bad++;
        $display("FAIL rnd_ready: cycle %0d got %b want %b", c, b.o_ready, q.size() < 2 || b.i_ready);
      end
      if (q.size() != 1) begin
        total++;
        if (b.o_valid !== (q.size() == 2)) begin
          bad++;
          $display("FAIL rnd_valid: cycle %0d got %b want %b", c, b.o_valid, q.size() == 2);
        end
      end
      if (stall) begin
        total++;
        if (out !== prev) begin
          bad++;
          $display("FAIL rnd_hold: cycle %0d got %b want %b", c, out, prev);
        end
      end
      stall = b.o_valid && !b.i_ready;
      prev = out;
      if (b.o_valid && b.i_ready) begin
        total++;
        if (q.size() == 0 || out !== {1'b1, q[0]}) begin
          bad++;
          $display("FAIL rnd_out: cycle %0d got %b want %b", c, out, q.size() == 0 ? 10'd0 : {1'b1, q[0]});
        end
        if (q.size() > 0) void'(q.pop_front());
      end
      if (b.i_valid && b.o_ready) q.push_back(model(b.i_compare_vec, b.i_entry_valid, b.i_partial_en, 2));
      @(posedge clk); #1;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL rnd_drain: got %0d outstanding want 0", q.size());
    end
  endtask

  task automatic test_reset_mid;
    b.i_ready = 1'b0;
    b.i_valid = 1'b1;
    b.i_entry_valid = 4'hF;
    b.i_partial_en = 1'b1;
    b.i_compare_vec = 16'h000F;
    @(posedge clk); #1;
    b.i_compare_vec = 16'h00F0;
    @(posedge clk); #1;
    b.i_valid = 1'b0;
    total++;
    if ({b.o_valid, b.o_ready} !== 2'b10) begin
      bad++;
      $display("FAIL mid_full: got valid/ready=%b%b want 10", b.o_valid, b.o_ready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({out, b.o_ready} !== {10'd0, 1'b1}) begin
      bad++;
      $display("FAIL mid_async: got out=%b ready=%b want out=0 ready=1", out, b.o_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    b.i_ready = 1'b1;
    b.i_valid = 1'b1;
    b.i_compare_vec = 16'h0C00;
    total++;
    if (b.o_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_ready: got %b want 1", b.o_ready);
    end
    @(posedge clk); #1;
    b.i_valid = 1'b0;
    total++;
    if (b.o_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_flushed: o_valid=%b one cycle after accept, want 0", b.o_valid);
    end
    @(posedge clk); #1;
    total++;
    if (out !== {1'b1, 1'b1, 3'd1, 3'd2, 2'd2}) begin
      bad++;
      $display("FAIL mid_after: got %b want %b", out, {1'b1, 1'b1, 3'd1, 3'd2, 2'd2});
    end
  endtask

  initial begin
    b.i_valid = 1'b0;
    b.i_ready = 1'b1;
    b.i_compare_vec = '0;
    b.i_entry_valid = 4'hF;
    b.i_partial_en = 1'b1;
    test_reset;
    test_basic;
    test_tie_mask;
    test_no_match;
    test_full_only;
    test_backpressure;
    test_random;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
